delay_timer: RTL and testbench
==============================

# delay_timer

Parametrised down-counting delay timer for the reaction-timer datapath; successor to the fixed 12-bit one-shot countdown. It captures a load value on `start`, decrements once per `clk1k` cycle and flags expiry. Over the 12-bit one-shot it adds:
- configurable width;
- periodic auto-reload mode;
- synchronous abort;
- optional pause;
- a one-cycle expiry pulse alongside the sticky expiry level.

It drives random-delay generation and the reaction timeout.

## Interface
- `WIDTH`, default 12: counter and load-value width in bits (≥ 2).
- `clk1k` input 1: system clock, 1 kHz tick domain, all logic on rising edge.
- `rst_n` input 1: synchronous active-low reset.
- `start` input 1: synchronous; when high at an edge, captures `load_val` and (re)starts the countdown.
- `load_val` input WIDTH: delay value N, unsigned.
- `mode` input 1: 0 = one-shot, 1 = periodic; sampled with `start` into a mode register.
- `pause` input 1: hold the countdown while high; only functional with `DELAY_TIMER_PAUSE_EN`.
- `abort` input 1: synchronous cancel; return to idle.
- `count` output WIDTH: current counter value (registered).
- `busy` output 1: high in RUN or PAUSED.
- `expired` output 1: sticky expiry level (one-shot mode only).
- `tick` output 1: one-cycle pulse on every expiry, in both modes.

## Operation
- States:
  - IDLE: reset / after abort.
  - RUN: counting.
  - PAUSED: holding.
  - DONE: one-shot expired.
- Priority at each edge: `rst_n` low > `abort` > `start` > `pause` > countdown.
- Reset (`rst_n`=0):
  - state IDLE.
  - `count`=0, `busy`=0, `expired`=0, `tick`=0.
  - load register = 0, mode register = 0.
- `abort`=1 in any state: go to IDLE, clear `count`, `expired` and `busy`; `tick`=0.
- `start`=1 in any state:
  - capture `load_val` into the load register and `mode` into the mode register.
  - set `count` = `load_val`, `expired`=0; go to RUN.
  - A `start` in RUN or PAUSED restarts cleanly.
- RUN with `count` ≠ 0: decrement `count` by 1.
- RUN with `count` = 0: assert `tick` for one cycle, then:
  - one-shot: set `expired`=1, go to DONE, `count` stays 0.
  - periodic: reload `count` from the load register, stay in RUN, `expired` stays 0.
- RUN with `pause`=1: go to PAUSED, `count` frozen. Pause wins over decrement and over expiry at `count`=0.
- PAUSED with `pause`=0: return to RUN. The first decrement occurs on the edge after release.
- DONE: hold until `start` or `abort`; `busy`=0.
- Arithmetic: unsigned, WIDTH bits. No underflow is possible because expiry is checked before decrement. N = 2^WIDTH−1 is legal.
- `tick` is 0 in every cycle other than an expiry cycle.

## Timing
- All outputs registered; no combinational input-to-output paths.
- Edge naming: `start` sampled at edge E0; `count`=N visible after E0, `busy`=1 after E0.
- Expiry occurs at edge E0+N+1: `tick`=1 and (one-shot) `expired`=1 are visible in that cycle. Latency is N+1 cycles.
- N=0: expiry at E0+1.
- Periodic mode: `tick` repeats every N+1 cycles.
- Each cycle spent in PAUSED adds exactly one cycle to the latency.
- A `start` coincident with the expiry edge wins: no `tick`, countdown restarts.
- An `abort` coincident with `start` wins: result is IDLE.

## Configuration
- `DELAY_TIMER_PAUSE_EN` defined:
  - PAUSED state and `pause` input are functional as above.
- Not defined:
  - `pause` port is present but ignored.
  - PAUSED state is not implemented.
  - RUN always decrements or expires.

## Test plan
- Reset: hold `rst_n`=0 3 cycles with `start`=1 → `count`=0, `busy`=0, `expired`=0, `tick`=0 throughout.
- One-shot: N=5, `mode`=0, pulse `start` → `count` reads 5,4,3,2,1,0; `tick` and `expired` rise 6 cycles after `start`; `expired` stays high 20 cycles; `busy` goes low.
- Periodic: N=3, `mode`=1 → `tick` pulses every 4 cycles for 5 periods; `expired` stays 0; `abort` → IDLE, `count`=0, `busy`=0.
- Pause (`DELAY_TIMER_PAUSE_EN`): N=10, `pause` high for 4 cycles starting at `count`=6 → `count` holds 6; expiry occurs 15 cycles after `start`. Without the macro, the same stimulus expires at 11 cycles.
- Collisions: `start` (N=2) on the expiry edge of a N=4 run → no `tick`, new expiry 3 cycles later; `abort`+`start` together → IDLE.
- Boundaries: N=0 → `tick` 1 cycle after `start`; WIDTH=4, N=15 → expiry at 16 cycles, no wrap.

Source files
------------

// File: rtl/delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : delay_timer
//  Description : Parametrised down-counting delay timer. Captures a load value
//                on start, decrements once per clk1k cycle and flags expiry
//                with a sticky level (one-shot) and a one-cycle tick pulse
//                (one-shot and periodic auto-reload). Synchronous abort.
//                Optional pause support is built when DELAY_TIMER_PAUSE_EN
//                is defined; otherwise the pause input is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_timer #(
    parameter int WIDTH = 12
) (
    input  logic             clk1k,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mode,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             tick
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] C_ZERO = '0;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_load;
    logic             r_mode;
    logic             r_busy;
    logic             r_expired;
    logic             r_tick;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_load_nxt;
    logic             w_mode_nxt;
    logic             w_busy_nxt;
    logic             w_expired_nxt;
    logic             w_tick_nxt;
    logic             w_pause;

`ifdef DELAY_TIMER_PAUSE_EN
    assign w_pause = pause;
`else
    // Pause is a no-op in this build; the port is kept for drop-in compatibility.
    logic w_pause_unused;
    assign w_pause_unused = pause;
    assign w_pause        = 1'b0;
`endif

    // Next-state and next-output logic; priority abort > start > pause > countdown.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_load_nxt    = r_load;
        w_mode_nxt    = r_mode;
        w_expired_nxt = r_expired;
        w_tick_nxt    = 1'b0;

        if (abort) begin
            w_state_nxt   = S_IDLE;
            w_count_nxt   = C_ZERO;
            w_expired_nxt = 1'b0;
        end else if (start) begin
            w_state_nxt   = S_RUN;
            w_load_nxt    = load_val;
            w_mode_nxt    = mode;
            w_count_nxt   = load_val;
            w_expired_nxt = 1'b0;
        end else begin
            case (r_state)
                // Releasing pause acts like a RUN cycle, so each paused cycle
                // costs exactly one cycle of latency.
                S_RUN, S_PAUSED: begin
                    if (w_pause) begin
                        w_state_nxt = S_PAUSED;
                    end else if (r_count == C_ZERO) begin
                        // Expiry is checked before decrement, so no underflow.
                        w_tick_nxt = 1'b1;
                        if (r_mode) begin
                            w_state_nxt = S_RUN;
                            w_count_nxt = r_load;
                        end else begin
                            w_state_nxt   = S_DONE;
                            w_expired_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_RUN;
                        w_count_nxt = r_count - C_ONE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_PAUSED);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk1k) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= C_ZERO;
            r_load    <= C_ZERO;
            r_mode    <= 1'b0;
            r_busy    <= 1'b0;
            r_expired <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            r_load    <= w_load_nxt;
            r_mode    <= w_mode_nxt;
            r_busy    <= w_busy_nxt;
            r_expired <= w_expired_nxt;
            r_tick    <= w_tick_nxt;
        end
    end

    assign count   = r_count;
    assign busy    = r_busy;
    assign expired = r_expired;
    assign tick    = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_delay_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_timer
//  Description : Self-checking bench for delay_timer. Expected tick cycles are
//                queued when start is driven and compared when tick appears.
//                Honours DELAY_TIMER_PAUSE_EN for the pause expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_timer;

    localparam int W = 12;

    logic         clk1k    = 1'b0;
    logic         rst_n    = 1'b0;
    logic         start    = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         mode     = 1'b0;
    logic         pause    = 1'b0;
    logic         abort    = 1'b0;
    logic [W-1:0] count;
    logic         busy;
    logic         expired;
    logic         tick;

    logic         start4   = 1'b0;
    logic [3:0]   load4    = '0;
    logic         mode4    = 1'b0;
    logic         pause4   = 1'b0;
    logic         abort4   = 1'b0;
    logic [3:0]   count4;
    logic         busy4;
    logic         expired4;
    logic         tick4;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int exp_q[$];
    int mon_e;

    delay_timer #(.WIDTH(W)) u_dut (
        .clk1k(clk1k), .rst_n(rst_n), .start(start), .load_val(load_val),
        .mode(mode), .pause(pause), .abort(abort),
        .count(count), .busy(busy), .expired(expired), .tick(tick)
    );

    delay_timer #(.WIDTH(4)) u_dut4 (
        .clk1k(clk1k), .rst_n(rst_n), .start(start4), .load_val(load4),
        .mode(mode4), .pause(pause4), .abort(abort4),
        .count(count4), .busy(busy4), .expired(expired4), .tick(tick4)
    );

    // Free-running clock.
    always #5 clk1k = ~clk1k;

    // Edge index: value after edge k is k.
    always @(posedge clk1k) cyc <= cyc + 1;

    // Scoreboard: every tick must match the oldest queued expiry cycle.
    always @(negedge clk1k) begin
        if (exp_q.size() > 0 && exp_q[0] < cyc) begin
            checks++;
            errors++;
            $display("FAIL tick_missing: no tick at cycle %0d (now %0d)", exp_q[0], cyc);
            mon_e = exp_q.pop_front();
        end
        if (tick === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: tick at cycle %0d, none expected", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e != cyc) begin
                    errors++;
                    $display("FAIL tick_time: tick at cycle %0d, expected cycle %0d", cyc, mon_e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk1k);
        #1;
    endtask

    task automatic check_q_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_queue: %0d ticks outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; load_val = W'(7); mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({count, busy, expired, tick} !== '0) begin
                errors++;
                $display("FAIL reset[%0d]: count=%0d busy=%b expired=%b tick=%b, expected all 0",
                         i, count, busy, expired, tick);
            end
        end
        rst_n = 1'b1; start = 1'b0; mode = 1'b0;
        step();
    endtask

    task automatic test_oneshot();
        int e0;
        load_val = W'(5); mode = 1'b0; start = 1'b1;
        step(); start = 1'b0; e0 = cyc;
        exp_q.push_back(e0 + 6);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (count !== W'(5 - i)) begin
                errors++;
                $display("FAIL oneshot_count[%0d]: got %0d, expected %0d", i, count, 5 - i);
            end
            if (i < 5) step();
        end
        checks++;
        if ({busy, expired} !== 2'b10) begin
            errors++;
            $display("FAIL oneshot_pre: busy=%b expired=%b, expected busy=1 expired=0", busy, expired);
        end
        step();
        checks++;
        if ({busy, expired} !== 2'b01 || count !== '0) begin
            errors++;
            $display("FAIL oneshot_expiry: busy=%b expired=%b count=%0d, expected 0,1,0", busy, expired, count);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (expired !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL oneshot_hold[%0d]: expired=%b busy=%b, expected 1,0", i, expired, busy);
            end
        end
        check_q_empty("oneshot");
    endtask

    task automatic test_periodic();
        int e0;
        load_val = W'(3); mode = 1'b1; start = 1'b1;
        step(); start = 1'b0; mode = 1'b0; e0 = cyc;
        for (int k = 1; k <= 5; k++) exp_q.push_back(e0 + 4 * k);
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (expired !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL periodic_level[%0d]: expired=%b busy=%b, expected 0,1", i, expired, busy);
            end
        end
        abort = 1'b1;
        step(); abort = 1'b0;
        checks++;
        if ({count, busy, expired} !== '0) begin
            errors++;
            $display("FAIL periodic_abort: count=%0d busy=%b expired=%b, expected all 0", count, busy, expired);
        end
        step();
        check_q_empty("periodic");
    endtask

    task automatic test_pause();
        int e0;
        int lat;
        int exp_c;
        bit seen;
`ifdef DELAY_TIMER_PAUSE_EN
        lat = 15;
`else
        lat = 11;
`endif
        load_val = W'(10); mode = 1'b0; start = 1'b1;
        step(); start = 1'b0; e0 = cyc;
        exp_q.push_back(e0 + lat);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (count !== W'(6)) begin
            errors++;
            $display("FAIL pause_pre: count=%0d, expected 6", count);
        end
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef DELAY_TIMER_PAUSE_EN
            exp_c = 6;
`else
            exp_c = 5 - k;
`endif
            checks++;
            if (count !== W'(exp_c)) begin
                errors++;
                $display("FAIL pause_hold[%0d]: count=%0d, expected %0d", k, count, exp_c);
            end
        end
        pause = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (expired === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || cyc != e0 + lat) begin
            errors++;
            $display("FAIL pause_latency: expired seen=%0d at %0d cycles, expected %0d",
                     seen, cyc - e0, lat);
        end
        step();
        check_q_empty("pause");
    endtask

    task automatic test_collision();
        int e1;
        load_val = W'(4); mode = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL collide_pre: count=%0d, expected 0", count);
        end
        load_val = W'(2); start = 1'b1;
        step(); start = 1'b0; e1 = cyc;
        exp_q.push_back(e1 + 3);
        checks++;
        if (count !== W'(2) || expired !== 1'b0) begin
            errors++;
            $display("FAIL collide_restart: count=%0d expired=%b, expected 2,0", count, expired);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (expired !== 1'b1) begin
            errors++;
            $display("FAIL collide_expiry: expired=%b at +3, expected 1", expired);
        end
        step();
        check_q_empty("collide");
        load_val = W'(7); start = 1'b1; abort = 1'b1;
        step(); start = 1'b0; abort = 1'b0;
        checks++;
        if ({count, busy, expired} !== '0) begin
            errors++;
            $display("FAIL abort_start: count=%0d busy=%b expired=%b, expected all 0", count, busy, expired);
        end
        step();
        checks++;
        if (count !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: count=%0d busy=%b, expected 0,0", count, busy);
        end
    endtask

    task automatic test_boundary();
        int e0;
        int t;
        bit found;
        load_val = '0; mode = 1'b0; start = 1'b1;
        step(); start = 1'b0; e0 = cyc;
        exp_q.push_back(e0 + 1);
        checks++;
        if (count !== '0 || busy !== 1'b1 || expired !== 1'b0) begin
            errors++;
            $display("FAIL n0_start: count=%0d busy=%b expired=%b, expected 0,1,0", count, busy, expired);
        end
        step();
        checks++;
        if (expired !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL n0_expiry: expired=%b busy=%b, expected 1,0", expired, busy);
        end
        step();
        check_q_empty("n0");

        load4 = 4'd15; start4 = 1'b1;
        step(); start4 = 1'b0; e0 = cyc;
        checks++;
        if (count4 !== 4'd15) begin
            errors++;
            $display("FAIL w4_load: count=%0d, expected 15", count4);
        end
        found = 1'b0; t = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick4 === 1'b1) begin
                found = 1'b1;
                t = cyc;
            end
        end
        checks++;
        if (!found || t != e0 + 16) begin
            errors++;
            $display("FAIL w4_latency: tick found=%0d after %0d cycles, expected 16", found, t - e0);
        end
        step();
        checks++;
        if (count4 !== 4'd0 || expired4 !== 1'b1 || busy4 !== 1'b0 || tick4 !== 1'b0) begin
            errors++;
            $display("FAIL w4_nowrap: count=%0d expired=%b busy=%b tick=%b, expected 0,1,0,0",
                     count4, expired4, busy4, tick4);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_pause();
        test_collision();
        test_boundary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
